// File: rtl/alu_exec_unit_pkg.sv
// -----------------------------------------------------------------------------
// alu_exec_unit_pkg
// Shared constants for the execute-stage back end:
//   - ALU_CTL codes produced by the ALU control decoder, including the two
//     shift codes on the otherwise unused 3-bit encodings
//   - FSM state encoding of the execute unit
//   - conditional-branch funct3 encodings
//   - is_shift_code(): true for the shift ALU_CTL codes
// Optional feature macro: ALU_EXEC_SHIFT_EN. The shift codes are always
// defined here; when the macro is undefined the execute unit treats them as
// undefined codes.
// -----------------------------------------------------------------------------
package alu_exec_unit_pkg;

    localparam logic [2:0] ALU_CTL_ADD      = 3'b000;
    localparam logic [2:0] ALU_CTL_SUB      = 3'b001;
    localparam logic [2:0] ALU_CTL_LESS_SIG = 3'b010;
    localparam logic [2:0] ALU_CTL_LESS_UNS = 3'b011;
    localparam logic [2:0] ALU_CTL_OR       = 3'b100;
    localparam logic [2:0] ALU_CTL_AND      = 3'b101;
    localparam logic [2:0] ALU_CTL_SLL      = 3'b110;
    localparam logic [2:0] ALU_CTL_SRL      = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic logic is_shift_code(input logic [2:0] ctl);
        return (ctl == ALU_CTL_SLL) || (ctl == ALU_CTL_SRL);
    endfunction

endpackage

// File: rtl/alu_exec_unit_branch_eval.sv
// -----------------------------------------------------------------------------
// alu_exec_branch_eval
// Combinational branch decision from the branch funct3 and the ALU result of
// the compare. Kept separate so a branch predictor checker can reuse it.
// Ports:
//   f3      in  3      branch funct3
//   result  in  WIDTH  ALU result of the compare operation
//   taken   out 1      branch decision (caller gates it with is_branch)
// -----------------------------------------------------------------------------
module alu_exec_branch_eval
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       f3,
    input  logic [WIDTH-1:0] result,
    output logic             taken
);

    logic is_zero;

    assign is_zero = (result == '0);

    // beq/bne look at the whole result; the less-than variants rely on the
    // SLT-style compare leaving its answer in bit 0.
    always_comb begin
        taken = 1'b0;
        case (f3)
            F3_BEQ:           taken = is_zero;
            F3_BNE:           taken = !is_zero;
            F3_BLT, F3_BLTU:  taken = result[0];
            F3_BGE, F3_BGEU:  taken = !result[0];
            default:          taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Execute-stage back end between ID/EX and EX/MEM. Takes the ALU_CTL code,
// computes a registered result, zero flag and branch decision, and hands them
// to the consumer through a valid/ready handshake. Single-cycle ops complete
// in one cycle and can be accepted back to back.
//
// Optional feature macro: ALU_EXEC_SHIFT_EN
//   defined   : SLL/SRL run on an iterative one-bit-per-cycle shifter
//               (latency max(1, shamt), o_busy high while shifting)
//   undefined : shifter not built, SLL/SRL give result 0 in one cycle
//
// Ports:
//   i_clk           in  1      clock
//   i_rst           in  1      synchronous active-high reset
//   i_valid         in  1      operation offered
//   o_ready         out 1      unit can accept an operation this cycle
//   i_alu_ctl       in  3      ALU_CTL code
//   i_op_a          in  WIDTH  operand A
//   i_op_b          in  WIDTH  operand B (shift amount in low SHAMT_W bits)
//   i_is_branch     in  1      op is a conditional branch compare
//   i_f3            in  3      branch funct3
//   o_valid         out 1      result held for the consumer
//   i_ready         in  1      consumer takes the result
//   o_result        out WIDTH  registered result
//   o_zero          out 1      o_result == 0
//   o_branch_taken  out 1      branch decision, 0 when not a branch
//   o_busy          out 1      iterative op in progress
// -----------------------------------------------------------------------------
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_alu_ctl,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic             i_is_branch,
    input  logic [2:0]       i_f3,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_branch_taken,
    output logic             o_busy
);

    state_t           state;
    logic             accept;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] eval_result;
    logic [2:0]       eval_f3;
    logic             eval_is_branch;
    logic             eval_taken;
    logic             taken_next;

    // HOLD can take a new op in the same cycle the consumer drains the
    // current one, which gives one op per cycle for single-cycle codes.
    assign o_ready = (state == IDLE) || ((state == HOLD) && i_ready);
    assign accept  = i_valid && o_ready;

    // Single-cycle datapath. A shift that reaches this result has shamt == 0,
    // so it simply passes operand A through.
    always_comb begin
        alu_result = '0;
        case (i_alu_ctl)
            ALU_CTL_ADD:      alu_result = i_op_a + i_op_b;
            ALU_CTL_SUB:      alu_result = i_op_a - i_op_b;
            ALU_CTL_LESS_SIG: alu_result = {{(WIDTH-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
            ALU_CTL_LESS_UNS: alu_result = {{(WIDTH-1){1'b0}}, (i_op_a < i_op_b)};
            ALU_CTL_OR:       alu_result = i_op_a | i_op_b;
            ALU_CTL_AND:      alu_result = i_op_a & i_op_b;
`ifdef ALU_EXEC_SHIFT_EN
            ALU_CTL_SLL,
            ALU_CTL_SRL:      alu_result = i_op_a;
`endif
            default:          alu_result = '0;
        endcase
    end

`ifdef ALU_EXEC_SHIFT_EN
    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    logic [WIDTH-1:0]   shift_reg;
    logic [WIDTH-1:0]   shift_step;
    logic [SHAMT_W-1:0] cnt;
    logic [SHAMT_W-1:0] shamt;
    logic               shift_left;
    logic               pend_branch;
    logic [2:0]         pend_f3;
    logic               start_shift;
    logic               busy_q;

    assign shamt       = i_op_b[SHAMT_W-1:0];
    assign start_shift = accept && is_shift_code(i_alu_ctl) && (shamt != '0);
    assign shift_step  = shift_left ? (shift_reg << 1) : (shift_reg >> 1);
    assign o_busy      = busy_q;

    // On the last shift cycle the branch decision must see the final shifted
    // value and the branch info captured at acceptance, not the live inputs.
    always_comb begin
        eval_result    = alu_result;
        eval_f3        = i_f3;
        eval_is_branch = i_is_branch;
        if (state == SHIFT) begin
            eval_result    = shift_step;
            eval_f3        = pend_f3;
            eval_is_branch = pend_branch;
        end
    end
`else
    assign o_busy         = 1'b0;
    assign eval_result    = alu_result;
    assign eval_f3        = i_f3;
    assign eval_is_branch = i_is_branch;
`endif

    alu_exec_branch_eval #(
        .WIDTH (WIDTH)
    ) u_branch_eval (
        .f3     (eval_f3),
        .result (eval_result),
        .taken  (eval_taken)
    );

    assign taken_next = eval_is_branch && eval_taken;

    // Control FSM with registered outputs. o_valid is high exactly in HOLD;
    // the output registers are only written when entering HOLD, so they stay
    // stable while the consumer stalls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            o_valid        <= 1'b0;
            o_result       <= '0;
            o_zero         <= 1'b0;
            o_branch_taken <= 1'b0;
`ifdef ALU_EXEC_SHIFT_EN
            busy_q         <= 1'b0;
            cnt            <= '0;
            shift_reg      <= '0;
            shift_left     <= 1'b0;
            pend_branch    <= 1'b0;
            pend_f3        <= '0;
`endif
        end
`ifdef ALU_EXEC_SHIFT_EN
        else if (state == SHIFT) begin
            shift_reg <= shift_step;
            cnt       <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
                state          <= HOLD;
                busy_q         <= 1'b0;
                o_valid        <= 1'b1;
                o_result       <= shift_step;
                o_zero         <= (shift_step == '0);
                o_branch_taken <= taken_next;
            end
        end
        else if (start_shift) begin
            state       <= SHIFT;
            busy_q      <= 1'b1;
            o_valid     <= 1'b0;
            shift_reg   <= i_op_a;
            cnt         <= shamt;
            shift_left  <= (i_alu_ctl == ALU_CTL_SLL);
            pend_branch <= i_is_branch;
            pend_f3     <= i_f3;
        end
`endif
        else if (accept) begin
            state          <= HOLD;
            o_valid        <= 1'b1;
            o_result       <= alu_result;
            o_zero         <= (alu_result == '0);
            o_branch_taken <= taken_next;
        end
        else if ((state == HOLD) && i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
// Self-checking bench for alu_exec_unit. Expected results are computed by a
// small reference model when an op is accepted, pushed to a queue, and
// popped when the unit hands a result to the consumer.
// Follows ALU_EXEC_SHIFT_EN so the same bench covers both builds.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    localparam int W  = 32;
    localparam int SW = 5;

    typedef struct packed {
        logic [W-1:0] result;
        logic         zero;
        logic         taken;
    } exp_t;

    logic         i_clk;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [2:0]   i_alu_ctl;
    logic [W-1:0] i_op_a;
    logic [W-1:0] i_op_b;
    logic         i_is_branch;
    logic [2:0]   i_f3;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_result;
    logic         o_zero;
    logic         o_branch_taken;
    logic         o_busy;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    alu_exec_unit #(
        .WIDTH   (W),
        .SHAMT_W (SW)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_alu_ctl      (i_alu_ctl),
        .i_op_a         (i_op_a),
        .i_op_b         (i_op_b),
        .i_is_branch    (i_is_branch),
        .i_f3           (i_f3),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_result       (o_result),
        .o_zero         (o_zero),
        .o_branch_taken (o_branch_taken),
        .o_busy         (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference model: written independently of the RTL datapath.
    function automatic exp_t model(input logic [2:0] ctl, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic br,
                                   input logic [2:0] f3);
        exp_t         e;
        logic [W-1:0] r;
        logic [W-1:0] msb;
        msb = {1'b1, {(W-1){1'b0}}};
        r   = '0;
        case (ctl)
            ALU_CTL_ADD:      r = a + b;
            ALU_CTL_SUB:      r = a + ~b + 1;
            ALU_CTL_LESS_SIG: r = ((a ^ msb) < (b ^ msb)) ? 1 : 0;
            ALU_CTL_LESS_UNS: r = (a < b) ? 1 : 0;
            ALU_CTL_OR:       r = a | b;
            ALU_CTL_AND:      r = a & b;
`ifdef ALU_EXEC_SHIFT_EN
            ALU_CTL_SLL:      r = a << b[SW-1:0];
            ALU_CTL_SRL:      r = a >> b[SW-1:0];
`endif
            default:          r = '0;
        endcase
        e.result = r;
        e.zero   = (r == 0);
        e.taken  = 1'b0;
        if (br) begin
            case (f3)
                3'b000:         e.taken = (r == 0);
                3'b001:         e.taken = (r != 0);
                3'b100, 3'b110: e.taken = r[0];
                3'b101, 3'b111: e.taken = ~r[0];
                default:        e.taken = 1'b0;
            endcase
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] ctl, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic br, input logic [2:0] f3);
        i_valid     = 1'b1;
        i_alu_ctl   = ctl;
        i_op_a      = a;
        i_op_b      = b;
        i_is_branch = br;
        i_f3        = f3;
    endtask

    task automatic note_accept();
        if (i_valid && o_ready)
            sb.push_back(model(i_alu_ctl, i_op_a, i_op_b, i_is_branch, i_f3));
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_alu_ctl = '0; i_op_a = '0; i_op_b = '0; i_is_branch = 1'b0; i_f3 = '0;
        tick();
        tick();
        i_rst = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", o_valid); end
        checks++; if (o_result !== '0) begin errors++; $display("[TB] FAIL reset_result: got %h want 0", o_result); end
        checks++; if (o_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_zero: got %b want 0", o_zero); end
        checks++; if (o_branch_taken !== 1'b0) begin errors++; $display("[TB] FAIL reset_taken: got %b want 0", o_branch_taken); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", o_busy); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", o_ready); end
        sb.delete();
        tick();
    endtask

    task automatic test_add_wrap();
        exp_t e;
        sb.delete();
        i_ready = 1'b1;
        set_op(ALU_CTL_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, 3'b000);
        #1; note_accept(); tick();
        i_valid = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_latency: got valid=%b want 1", o_valid); end
        if (o_valid && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({o_result, o_zero, o_branch_taken} !== {e.result, e.zero, e.taken}) begin
                errors++; $display("[TB] FAIL add_out: got %h/%b/%b want %h/%b/%b", o_result, o_zero, o_branch_taken, e.result, e.zero, e.taken);
            end
            checks++;
            if (o_result !== 32'h0 || o_zero !== 1'b1) begin
                errors++; $display("[TB] FAIL add_wrap: got %h/%b want 00000000/1", o_result, o_zero);
            end
        end
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_release: got valid=%b want 0", o_valid); end
    endtask

    task automatic test_branch();
        exp_t e;
        sb.delete();
        i_ready = 1'b1;
        set_op(ALU_CTL_LESS_SIG, 32'h8000_0000, 32'h0, 1'b1, 3'b100);
        #1; note_accept(); tick();
        set_op(ALU_CTL_LESS_UNS, 32'h8000_0000, 32'h0, 1'b1, 3'b110);
        #1;
        checks++;
        if (o_valid !== 1'b1 || o_result !== 32'd1 || o_branch_taken !== 1'b1) begin
            errors++; $display("[TB] FAIL branch_blt: got v=%b r=%h t=%b want v=1 r=00000001 t=1", o_valid, o_result, o_branch_taken);
        end
        if (o_valid && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({o_result, o_zero, o_branch_taken} !== {e.result, e.zero, e.taken}) begin
                errors++; $display("[TB] FAIL branch_blt_sb: got %h/%b/%b want %h/%b/%b", o_result, o_zero, o_branch_taken, e.result, e.zero, e.taken);
            end
        end
        note_accept(); tick();
        i_valid = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b1 || o_result !== 32'd0 || o_branch_taken !== 1'b0) begin
            errors++; $display("[TB] FAIL branch_bltu: got v=%b r=%h t=%b want v=1 r=00000000 t=0", o_valid, o_result, o_branch_taken);
        end
        if (o_valid && sb.size() > 0) void'(sb.pop_front());
        tick();

        // Every funct3 against an equal and an unequal SUB, back to back.
        for (int k = 0; k < 16; k++) begin
            if (k[0]) set_op(ALU_CTL_SUB, 32'd9, 32'd4, 1'b1, 3'(k >> 1));
            else      set_op(ALU_CTL_SUB, 32'd7, 32'd7, 1'b1, 3'(k >> 1));
            #1;
            if (o_valid && i_ready && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({o_result, o_zero, o_branch_taken} !== {e.result, e.zero, e.taken}) begin
                    errors++; $display("[TB] FAIL branch_f3_%0d: got %h/%b/%b want %h/%b/%b", k, o_result, o_zero, o_branch_taken, e.result, e.zero, e.taken);
                end
            end
            note_accept(); tick();
        end
        i_valid = 1'b0;
        #1;
        if (o_valid && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({o_result, o_zero, o_branch_taken} !== {e.result, e.zero, e.taken}) begin
                errors++; $display("[TB] FAIL branch_f3_last: got %h/%b/%b want %h/%b/%b", o_result, o_zero, o_branch_taken, e.result, e.zero, e.taken);
            end
        end
        tick();
        checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL branch_count: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        exp_t         e;
        logic [2:0]   ctls  [3];
        logic [W-1:0] opa   [3];
        logic [W-1:0] opb   [3];
        logic [W-1:0] wants [3];
        int idx, outs, cyc;
        ctls  = '{ALU_CTL_SUB, ALU_CTL_OR, ALU_CTL_AND};
        opa   = '{32'd5, 32'hF0, 32'hFF};
        opb   = '{32'd3, 32'h0F, 32'h0F};
        wants = '{32'd2, 32'hFF, 32'h0F};
        sb.delete();
        idx = 0; outs = 0; cyc = 0;
        while (outs < 3 && cyc < 40) begin
            i_ready = (cyc >= 5);
            if (idx < 3) set_op(ctls[idx], opa[idx], opb[idx], 1'b0, 3'b000);
            else         i_valid = 1'b0;
            #1;
            if (o_valid && !i_ready) begin
                checks++;
                if (o_result !== 32'd2) begin errors++; $display("[TB] FAIL bp_hold: got %h want 00000002", o_result); end
            end
            if (o_valid && i_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("[TB] FAIL bp_extra: got unexpected output %h want none", o_result);
                end else begin
                    e = sb.pop_front();
                    if (o_result !== wants[outs] || {o_result, o_zero, o_branch_taken} !== {e.result, e.zero, e.taken}) begin
                        errors++; $display("[TB] FAIL bp_out%0d: got %h/%b want %h/%b", outs, o_result, o_zero, wants[outs], e.zero);
                    end
                end
                outs++;
            end
            if (i_valid && o_ready) begin
                note_accept();
                idx++;
            end
            tick();
            cyc++;
        end
        i_valid = 1'b0;
        checks++; if (outs != 3) begin errors++; $display("[TB] FAIL bp_timeout: got %0d outputs want 3", outs); end
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_dup: got valid=%b want 0", o_valid); end
        tick();
    endtask

    task automatic test_shift();
        exp_t e;
        sb.delete();
        i_ready = 1'b1;
`ifdef ALU_EXEC_SHIFT_EN
        begin
            int n, busy;
            set_op(ALU_CTL_SLL, 32'd1, 32'd5, 1'b0, 3'b000);
            #1; note_accept(); tick();
            i_valid = 1'b0;
            n = 0; busy = 0;
            #1;
            while (o_valid !== 1'b1 && n < 40) begin
                if (o_busy === 1'b1 && o_ready === 1'b0) busy++;
                n++;
                tick();
                #1;
            end
            checks++; if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL sll_timeout: got no result want valid"); end
            checks++; if (busy != 5) begin errors++; $display("[TB] FAIL sll_busy: got %0d cycles want 5", busy); end
            checks++; if (o_result !== 32'h20) begin errors++; $display("[TB] FAIL sll_result: got %h want 00000020", o_result); end
            if (o_valid && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({o_result, o_zero, o_branch_taken} !== {e.result, e.zero, e.taken}) begin
                    errors++; $display("[TB] FAIL sll_sb: got %h/%b/%b want %h/%b/%b", o_result, o_zero, o_branch_taken, e.result, e.zero, e.taken);
                end
            end
            tick();
            set_op(ALU_CTL_SRL, 32'h8000_0000, 32'd0, 1'b0, 3'b000);
            #1; note_accept(); tick();
            i_valid = 1'b0;
            #1;
            checks++;
            if (o_valid !== 1'b1 || o_busy !== 1'b0 || o_result !== 32'h8000_0000) begin
                errors++; $display("[TB] FAIL srl_zero: got v=%b b=%b r=%h want v=1 b=0 r=80000000", o_valid, o_busy, o_result);
            end
            if (o_valid && sb.size() > 0) void'(sb.pop_front());
            tick();
        end
`else
        set_op(ALU_CTL_SLL, 32'd1, 32'd5, 1'b0, 3'b000);
        #1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL noshift_busy0: got %b want 0", o_busy); end
        note_accept(); tick();
        i_valid = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b1 || o_busy !== 1'b0 || o_result !== 32'h0) begin
            errors++; $display("[TB] FAIL noshift_out: got v=%b b=%b r=%h want v=1 b=0 r=00000000", o_valid, o_busy, o_result);
        end
        if (o_valid && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({o_result, o_zero, o_branch_taken} !== {e.result, e.zero, e.taken}) begin
                errors++; $display("[TB] FAIL noshift_sb: got %h/%b/%b want %h/%b/%b", o_result, o_zero, o_branch_taken, e.result, e.zero, e.taken);
            end
        end
        tick();
`endif
    endtask

    task automatic test_reset_midop();
        exp_t e;
        sb.delete();
        i_ready = 1'b0;
        set_op(ALU_CTL_ADD, 32'd2, 32'd3, 1'b0, 3'b000);
        #1; tick();
        i_valid = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b1 || o_result !== 32'd5) begin errors++; $display("[TB] FAIL hold_pre: got v=%b r=%h want v=1 r=00000005", o_valid, o_result); end
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_result !== '0) begin errors++; $display("[TB] FAIL hold_rst: got v=%b r=%h want v=0 r=00000000", o_valid, o_result); end

        set_op(ALU_CTL_SLL, 32'd1, 32'd20, 1'b0, 3'b000);
        #1; tick();
        i_valid = 1'b0;
        tick(); tick();
        #1;
`ifdef ALU_EXEC_SHIFT_EN
        checks++; if (o_busy !== 1'b1) begin errors++; $display("[TB] FAIL shift_pre: got busy=%b want 1", o_busy); end
`endif
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_result !== '0 || o_busy !== 1'b0 || o_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL shift_rst: got v=%b r=%h b=%b rdy=%b want v=0 r=00000000 b=0 rdy=1", o_valid, o_result, o_busy, o_ready);
        end
        sb.delete();
        i_ready = 1'b1;
        set_op(ALU_CTL_ADD, 32'd2, 32'd2, 1'b0, 3'b000);
        #1; note_accept(); tick();
        i_valid = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b1 || o_result !== 32'd4) begin errors++; $display("[TB] FAIL post_rst_add: got v=%b r=%h want v=1 r=00000004", o_valid, o_result); end
        if (o_valid && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({o_result, o_zero, o_branch_taken} !== {e.result, e.zero, e.taken}) begin
                errors++; $display("[TB] FAIL post_rst_sb: got %h/%b/%b want %h/%b/%b", o_result, o_zero, o_branch_taken, e.result, e.zero, e.taken);
            end
        end
        tick();
    endtask

    task automatic test_random();
        exp_t       e;
        logic       held;
        logic [W+2:0] held_val;
        int n;
        sb.delete();
        held = 1'b0;
        held_val = '0;
        for (int c = 0; c < 150; c++) begin
            i_valid     = 1'($urandom_range(0, 1));
            i_alu_ctl   = 3'($urandom_range(0, 7));
            i_op_a      = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom());
            i_op_b      = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom());
            i_is_branch = 1'($urandom_range(0, 1));
            i_f3        = 3'($urandom_range(0, 7));
            i_ready     = ($urandom_range(0, 3) != 0);
            #1;
            if (held) begin
                checks++;
                if ({o_valid, o_result, o_zero, o_branch_taken} !== held_val) begin
                    errors++; $display("[TB] FAIL rand_stable: got %h want %h", {o_valid, o_result, o_zero, o_branch_taken}, held_val);
                end
            end
            if (o_valid && i_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("[TB] FAIL rand_extra: got output %h want none", o_result);
                end else begin
                    e = sb.pop_front();
                    if ({o_result, o_zero, o_branch_taken} !== {e.result, e.zero, e.taken}) begin
                        errors++; $display("[TB] FAIL rand_out: got %h/%b/%b want %h/%b/%b", o_result, o_zero, o_branch_taken, e.result, e.zero, e.taken);
                    end
                end
            end
            held     = o_valid && !i_ready;
            held_val = {o_valid, o_result, o_zero, o_branch_taken};
            note_accept();
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        n = 0;
        #1;
        while ((sb.size() > 0 || o_valid) && n < 100) begin
            if (o_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("[TB] FAIL rand_drain_extra: got output %h want none", o_result);
                end else begin
                    e = sb.pop_front();
                    if ({o_result, o_zero, o_branch_taken} !== {e.result, e.zero, e.taken}) begin
                        errors++; $display("[TB] FAIL rand_drain: got %h/%b/%b want %h/%b/%b", o_result, o_zero, o_branch_taken, e.result, e.zero, e.taken);
                    end
                end
            end
            n++;
            tick();
            #1;
        end
        checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL rand_lost: got %0d pending want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_branch();
        test_back_to_back();
        test_shift();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion want finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage back end that consumes the 3-bit ALU_CTL code from the ALU control decoder and returns a registered result, zero flag and branch decision.
- Sits between ID/EX and EX/MEM. Uses a valid/ready handshake on both sides so the pipeline can stall on a multi-cycle op.
- Single-cycle ops complete in 1 cycle. The optional iterative shifter adds an FSM path that takes multiple cycles.

Parameters:
- WIDTH, 32, operand/result width in bits (power of two, at least 8).
- SHAMT_W, $clog2(WIDTH), width of the shift-amount and cycle counter.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  operation offered
- o_ready  out  1  unit can accept an operation this cycle
- i_alu_ctl  in  3  ALU_CTL code
- i_op_a  in  WIDTH  operand A
- i_op_b  in  WIDTH  operand B (shift amount in low SHAMT_W bits)
- i_is_branch  in  1  op is a conditional branch compare
- i_f3  in  3  funct3, used only when i_is_branch=1
- o_valid  out  1  result held for the consumer
- i_ready  in  1  consumer takes the result
- o_result  out  WIDTH  registered result
- o_zero  out  1  o_result == 0
- o_branch_taken  out  1  branch decision, 0 when not a branch
- o_busy  out  1  iterative op in progress

Behaviour:
- Clocking and reset
  - One clock, i_clk. Reset i_rst is synchronous and active-high.
  - On reset: state=IDLE; o_valid=0, o_result=0, o_zero=0, o_branch_taken=0, o_busy=0. Any in-flight op is dropped.
- Handshake
  - Accept when i_valid && o_ready on a rising edge. Inputs are sampled only at acceptance.
  - Output transfer occurs when o_valid && i_ready.
  - o_result, o_zero and o_branch_taken are stable while o_valid=1 && i_ready=0.
- FSM states: IDLE, SHIFT, HOLD.
  - o_ready = (state==IDLE) || (state==HOLD && i_ready). Back-to-back accepts are allowed: 1 op/cycle for single-cycle ops.
  - IDLE + accept, single-cycle op: go to HOLD with the result registered (latency 1; o_valid=1 the next cycle).
  - IDLE + accept, shift op with shamt==0: go to HOLD with o_result=op_a.
  - IDLE + accept, shift op with shamt>0: go to SHIFT, cnt=shamt, o_busy=1.
  - SHIFT: each cycle shift by 1 and decrement cnt. When cnt==1 the final shift is performed and the FSM goes to HOLD.
  - Shift latency is max(1, shamt) cycles. o_ready=0 throughout SHIFT.
  - HOLD: if i_ready && i_valid, accept the next op per the IDLE rules. If i_ready && !i_valid, go to IDLE with o_valid=0. Otherwise hold.
- Arithmetic (modulo 2^WIDTH)
  - ADD: a+b.
  - SUB: a-b.
  - LESS_SIG: {0.., $signed(a)<$signed(b)}.
  - LESS_UNS: {0.., a<b}.
  - OR: a|b.
  - AND: a&b.
  - Undefined codes: result 0.
- Branch decision (when i_is_branch=1)
  - f3 000 (beq): taken = zero.
  - f3 001 (bne): taken = !zero.
  - f3 100 / 110 (blt / bltu): taken = result[0].
  - f3 101 / 111 (bge / bgeu): taken = !result[0].
  - f3 010 / 011: taken = 0.
  - Decision is registered alongside the result.
- Boundaries
  - Overflow wraps.
  - SUB of 0 - 1 gives all ones.
  - LESS_SIG with most-negative vs 0 gives 1.
  - Reset asserted while in SHIFT or HOLD returns to IDLE next edge with outputs cleared.

Optional Feature:
- Macro ALU_EXEC_SHIFT_EN.
- Defined: adds codes ALU_CTL_SLL and ALU_CTL_SRL (logical), executed by the iterative SHIFT path above.
- Undefined: the SHIFT state and counter are not built. Those codes behave as undefined codes: result 0, latency 1, o_busy tied 0.

Decomposition:
- Constants.vh holds ALU_CTL_ADD/SUB/LESS_SIG/LESS_UNS/OR/AND. It gains ALU_CTL_SLL/SRL on the two unused 3-bit encodings, plus the FSM state encodings and the branch funct3 constants.
- One sub-module, alu_exec_branch_eval: combinational f3 + result -> taken. Reused by a future branch predictor checker.

Test Plan:
- ADD: a=0xFFFFFFFF, b=1, i_ready=1 -> o_valid 1 cycle after accept, o_result=0, o_zero=1.
- Branch: LESS_SIG a=0x80000000, b=0, is_branch=1, f3=100 -> result=1, taken=1. Same operands with LESS_UNS, f3=110 -> result=0, taken=0.
- Backpressure: 3 back-to-back ops (SUB 5-3, OR 0xF0|0x0F, AND 0xFF&0x0F), i_ready=0 for 4 cycles then 1 -> outputs hold 2 until released, then 2, 0xFF, 0x0F in order. No loss, no duplicate.
- With ALU_EXEC_SHIFT_EN: SLL a=1, b=5 -> o_busy=1, o_ready=0 for 5 cycles, result 0x20. SRL a=0x80000000, b=0 -> result 0x80000000 after 1 cycle.
- Reset: assert i_rst during SHIFT (shamt=20, cycle 3) -> next edge IDLE, o_valid=0, o_result=0, o_busy=0. A new ADD 2+2 then yields 4.
- Without macro: SLL code with a=1, b=5 -> result 0 after 1 cycle, o_busy never asserted.
